// File: rtl/branch_predictor_pkg.sv
// Shared opcodes, 2-bit counter encodings and the saturating-counter helper for the branch predictor.
// Consumed by branch_predictor (top) and bp_btb.
package branch_predictor_pkg;

    localparam logic [6:0] OP_B_TYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != CTR_ST) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != CTR_SNT) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-resolution signal bundle of the branch predictor.
// Optional BP_STATS_EN adds the two statistics counters.
interface branch_predictor_if #(
    parameter int PC_W = 32
);
    // No backpressure: ex_valid alone qualifies the ex_* fields for one cycle;
    // a bubble (ex_valid=0) neither trains nor raises ex_mispredict.
    logic [PC_W-1:0] if_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [6:0]      ex_opcode;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pred_target;
    logic            ex_mispredict;
    logic [PC_W-1:0] ex_redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    modport master (
        output if_pc, ex_valid, ex_pc, ex_opcode, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
`ifdef BP_STATS_EN
        input  stat_branches, stat_mispredicts,
`endif
        input  pred_taken, pred_target, ex_mispredict, ex_redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_opcode, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
`ifdef BP_STATS_EN
        output stat_branches, stat_mispredicts,
`endif
        output pred_taken, pred_target, ex_mispredict, ex_redirect_pc
    );

endinterface

// File: rtl/branch_predictor_btb.sv
// bp_btb: direct-mapped BTB/BHT storage with two async read ports (fetch, EX),
// one synchronous write port and async clear.
module bp_btb
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int PC_W    = 32,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int TAG_W  = PC_W - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic             rd_is_jal,
    output logic [TAG_W-1:0] rd_tag,
    output logic [PC_W-1:0]  rd_target,
    output logic [1:0]       rd_ctr,
    input  logic [IDX_W-1:0] ex_idx,
    output logic             ex_valid,
    output logic             ex_is_jal,
    output logic [TAG_W-1:0] ex_tag,
    output logic [PC_W-1:0]  ex_target,
    output logic [1:0]       ex_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic             wr_is_jal,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PC_W-1:0]  wr_target,
    input  logic [1:0]       wr_ctr
);

    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0]            is_jal_q, is_jal_d;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ENTRIES-1:0][PC_W-1:0]  target_q, target_d;
    logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;

    // Reads return the registered contents, so a same-cycle write is not bypassed.
    assign rd_valid  = valid_q[rd_idx];
    assign rd_is_jal = is_jal_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];

    assign ex_valid  = valid_q[ex_idx];
    assign ex_is_jal = is_jal_q[ex_idx];
    assign ex_tag    = tag_q[ex_idx];
    assign ex_target = target_q[ex_idx];
    assign ex_ctr    = ctr_q[ex_idx];

    always_comb begin
        valid_d  = valid_q;
        is_jal_d = is_jal_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (wr_en) begin
            valid_d[wr_idx]  = wr_valid;
            is_jal_d[wr_idx] = wr_is_jal;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
            ctr_d[wr_idx]    = wr_ctr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            is_jal_q <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {ENTRIES{CTR_WNT}};
        end else begin
            valid_q  <= valid_d;
            is_jal_q <= is_jal_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: IF-stage BTB + 2-bit counter predictor trained from EX resolution.
// Define BP_STATS_EN to add the stat_branches / stat_mispredicts counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int PC_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;

    logic             rd_valid, rd_is_jal;
    logic [TAG_W-1:0] rd_tag;
    logic [PC_W-1:0]  rd_target;
    logic [1:0]       rd_ctr;
    logic             ent_valid, ent_is_jal;
    logic [TAG_W-1:0] ent_tag;
    logic [PC_W-1:0]  ent_target;
    logic [1:0]       ent_ctr;

    logic             wr_en, wr_valid, wr_is_jal;
    logic [TAG_W-1:0] wr_tag;
    logic [PC_W-1:0]  wr_target;
    logic [1:0]       wr_ctr;

    logic if_hit, ex_hit, op_b, op_jal, op_jalr;

    assign if_idx = bp.if_pc[IDX_W+1:2];
    assign if_tag = bp.if_pc[PC_W-1:IDX_W+2];
    assign ex_idx = bp.ex_pc[IDX_W+1:2];
    assign ex_tag = bp.ex_pc[PC_W-1:IDX_W+2];

    bp_btb #(.ENTRIES(ENTRIES), .PC_W(PC_W)) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_idx),
        .rd_valid  (rd_valid),
        .rd_is_jal (rd_is_jal),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .rd_ctr    (rd_ctr),
        .ex_idx    (ex_idx),
        .ex_valid  (ent_valid),
        .ex_is_jal (ent_is_jal),
        .ex_tag    (ent_tag),
        .ex_target (ent_target),
        .ex_ctr    (ent_ctr),
        .wr_en     (wr_en),
        .wr_idx    (ex_idx),
        .wr_valid  (wr_valid),
        .wr_is_jal (wr_is_jal),
        .wr_tag    (wr_tag),
        .wr_target (wr_target),
        .wr_ctr    (wr_ctr)
    );

    assign if_hit         = rd_valid && (rd_tag == if_tag);
    assign bp.pred_taken  = if_hit && (rd_is_jal || rd_ctr[1]);
    assign bp.pred_target = bp.pred_taken ? rd_target : '0;

    assign ex_hit  = ent_valid && (ent_tag == ex_tag);
    assign op_b    = (bp.ex_opcode == OP_B_TYPE);
    assign op_jal  = (bp.ex_opcode == OP_JAL);
    assign op_jalr = (bp.ex_opcode == OP_JALR);

    // Training write: default rewrites the current entry unchanged, then each case edits it.
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = ent_valid;
        wr_is_jal = ent_is_jal;
        wr_tag    = ex_tag;
        wr_target = ent_target;
        wr_ctr    = ent_ctr;
        if (bp.ex_valid) begin
            if (op_b) begin
                if (ex_hit) begin
                    wr_en  = 1'b1;
                    wr_ctr = ctr_update(ent_ctr, bp.ex_taken);
                    if (bp.ex_taken) begin
                        wr_target = bp.ex_target;
                    end
                end else if (bp.ex_taken) begin
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_is_jal = 1'b0;
                    wr_target = bp.ex_target;
                    wr_ctr    = CTR_WT;
                end
            end else if (op_jal) begin
                wr_en     = 1'b1;
                wr_valid  = 1'b1;
                wr_is_jal = 1'b1;
                wr_target = bp.ex_target;
                wr_ctr    = CTR_ST;
            end else if (!op_jalr && ex_hit) begin
                // A non-control instruction owns this PC, so the entry is stale.
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    assign bp.ex_mispredict = bp.ex_valid &&
                              ((bp.ex_taken != bp.ex_pred_taken) ||
                               (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)) ||
                               (op_jalr && bp.ex_taken));
    assign bp.ex_redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + PC_W'(4);

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (bp.ex_valid && (op_b || op_jal || op_jalr)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (bp.ex_mispredict) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign bp.stat_branches    = stat_branches_q;
    assign bp.stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
